adc_serial_rx: RTL and testbench

Serial receive stage directly downstream of the ADC conversion controller. Deserialises the controller's MSB-first serial result, framed by its data-mark strobe, into parallel words. Buffers words in a small first-word-fall-through FIFO with a valid/ready output toward the register and output-pad logic. Optionally cross-checks each received word against the controller's parallel result.

---
 rtl/adc_rx_pkg.sv | 13 +
 rtl/adc_rx_fifo.sv | 71 +++++++
 rtl/adc_serial_rx.sv | 174 +++++++++++++++++
 tb/tb_adc_serial_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_rx_pkg.sv
// Shared types and default sizes for the ADC serial receive stage.
package adc_rx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDrain
    } rx_state_e;

    localparam int unsigned AdcRxW     = 8;
    localparam int unsigned AdcRxDepth = 4;

endpackage

// File: rtl/adc_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is always presented on rdata_o.
module adc_rx_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     push_ok_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    assign rdata_o   = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign push_ok_o = push_ok;

endmodule

// File: rtl/adc_serial_rx.sv
// Deserialises the ADC controller's MSB-first framed result into a FWFT FIFO.
// Define ADC_RX_CHECK_EN to cross-check each word against the parallel result b_par.
module adc_serial_rx
    import adc_rx_pkg::*;
#(
    parameter int unsigned W     = AdcRxW,
    parameter int unsigned DEPTH = AdcRxDepth
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     data_mark,
    input  logic                     serial_in,
    input  logic                     load_reg,
    input  logic [W-1:0]             b_par,
    output logic [W-1:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     frame_err,
    output logic                     mismatch
);

    localparam int unsigned CntW = $clog2(W) + 1;

    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-2:0]    shift_q, shift_d;
    logic            frame_err_q, frame_err_d;
    logic            overflow_q, overflow_d;
    logic            mismatch_q, mismatch_d;

    logic [W-1:0]    word;
    logic            word_done;
    logic            fifo_full, fifo_empty, fifo_pop, fifo_push_ok;

    assign word = {shift_q, serial_in};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (data_mark) begin
                    shift_d    = '0;
                    shift_d[0] = serial_in;
                    cnt_d      = CntW'(1);
                    state_d    = StShift;
                end
            end
            StShift: begin
                if (data_mark) begin
                    if (cnt_q == CntW'(W - 1)) begin
                        word_done = 1'b1;
                        cnt_d     = '0;
                        state_d   = StDrain;
                    end else begin
                        shift_d = word[W-2:0];
                        cnt_d   = cnt_q + 1'b1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StIdle;
                end
            end
            StDrain: begin
                // cnt_q == 0 marks the first over-length cycle; later ones are ignored.
                if (data_mark) begin
                    if (cnt_q == '0) begin
                        frame_err_d = 1'b1;
                        cnt_d       = CntW'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    assign fifo_pop   = out_valid & out_ready;
    assign overflow_d = overflow_q | (word_done & ~fifo_push_ok);

    adc_rx_fifo #(
        .Width (W),
        .Depth (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push_i    (word_done),
        .wdata_i   (word),
        .pop_i     (fifo_pop),
        .rdata_o   (out_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .push_ok_o (fifo_push_ok),
        .count_o   (fifo_count)
    );

    assign out_valid = ~fifo_empty;

`ifdef ADC_RX_CHECK_EN
    logic [W-1:0] ref_q, ref_d;
    logic         ref_vld_q, ref_vld_d;
    logic [W-1:0] ref_sel;
    logic         ref_sel_vld;

    // A load_reg coinciding with word completion is the newest reference, so it is used directly.
    assign ref_sel     = load_reg ? b_par : ref_q;
    assign ref_sel_vld = load_reg | ref_vld_q;

    always_comb begin
        ref_d      = ref_q;
        ref_vld_d  = ref_vld_q;
        mismatch_d = 1'b0;
        if (load_reg) begin
            ref_d     = b_par;
            ref_vld_d = 1'b1;
        end
        if (word_done) begin
            mismatch_d = ref_sel_vld & (word != ref_sel);
            ref_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ref_q     <= '0;
            ref_vld_q <= 1'b0;
        end else begin
            ref_q     <= ref_d;
            ref_vld_q <= ref_vld_d;
        end
    end
`else
    logic unused_chk;
    assign unused_chk = ^{load_reg, b_par};
    assign mismatch_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            mismatch_q  <= mismatch_d;
        end
    end

    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign mismatch  = mismatch_q;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_adc_serial_rx.sv
// Directed, table-driven bench for adc_serial_rx (W=8, DEPTH=4).
module tb_adc_serial_rx;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       data_mark;
    logic       serial_in;
    logic       load_reg;
    logic [7:0] b_par;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       frame_err;
    logic       mismatch;

    adc_serial_rx #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .data_mark  (data_mark),
        .serial_in  (serial_in),
        .load_reg   (load_reg),
        .b_par      (b_par),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .mismatch   (mismatch)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ferr_cnt = 0;
    int mism_cnt = 0;
    logic [7:0] got_q[$];

    // Consumer-side monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (clr) begin
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (frame_err) ferr_cnt++;
            if (mismatch) mism_cnt++;
        end
    end

    typedef struct {
        logic [7:0] data;
        int         len;
        int         exp_n;
        logic [7:0] exp_word;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        ferr_cnt = 0;
        mism_cnt = 0;
    endtask

    task automatic do_reset();
        clr       = 1'b0;
        data_mark = 1'b0;
        serial_in = 1'b0;
        load_reg  = 1'b0;
        b_par     = 8'h00;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clear_mon();
    endtask

    // Drives nbits cycles of data_mark=1, MSB first; zeros beyond bit 7.
    task automatic send_bits(input logic [7:0] d, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            data_mark = 1'b1;
            serial_in = (i < 8) ? d[7 - i] : 1'b0;
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits);
        send_bits(d, nbits);
        data_mark = 1'b0;
        serial_in = 1'b0;
        tick();
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        for (int k = 0; k < 40 && got_q.size() < n; k++) tick();
    endtask

    initial begin
        logic [7:0] w;

        vecs[0] = '{8'hA5, 8,  1, 8'hA5, 0};
        vecs[1] = '{8'h1F, 5,  0, 8'h00, 1};
        vecs[2] = '{8'h3C, 8,  1, 8'h3C, 0};
        vecs[3] = '{8'hF0, 10, 1, 8'hF0, 1};
        vecs[4] = '{8'h00, 8,  1, 8'h00, 0};
        vecs[5] = '{8'hFF, 8,  1, 8'hFF, 0};
        vecs[6] = '{8'h81, 9,  1, 8'h81, 1};
        vecs[7] = '{8'h80, 1,  0, 8'h00, 1};

        out_ready = 1'b0;
        do_reset();

        check("rst_out_valid",  {31'b0, out_valid}, 32'd0);
        check("rst_fifo_count", {29'b0, fifo_count}, 32'd0);
        check("rst_overflow",   {31'b0, overflow}, 32'd0);
        check("rst_frame_err",  {31'b0, frame_err}, 32'd0);
        check("rst_mismatch",   {31'b0, mismatch}, 32'd0);
        check("rst_out_data",   {24'b0, out_data}, 32'd0);

        // Latency: word visible the cycle after the 8th bit, popped on the next edge.
        out_ready = 1'b1;
        send_bits(8'hA5, 8);
        check("lat_out_valid",  {31'b0, out_valid}, 32'd1);
        check("lat_out_data",   {24'b0, out_data}, 32'hA5);
        check("lat_fifo_count", {29'b0, fifo_count}, 32'd1);
        data_mark = 1'b0;
        tick();
        check("lat_count_after_pop", {29'b0, fifo_count}, 32'd0);
        check("lat_valid_after_pop", {31'b0, out_valid}, 32'd0);
        tick();

        // Frame table with a ready consumer.
        for (int v = 0; v < 8; v++) begin
            clear_mon();
            send_frame(vecs[v].data, vecs[v].len);
            repeat (3) tick();
            check($sformatf("vec%0d_words", v), got_q.size(), vecs[v].exp_n);
            check($sformatf("vec%0d_frame_err", v), ferr_cnt, vecs[v].exp_ferr);
            if (vecs[v].exp_n == 1) begin
                w = (got_q.size() > 0) ? got_q[0] : 8'hxx;
                check($sformatf("vec%0d_word", v), {24'b0, w}, {24'b0, vecs[v].exp_word});
            end
        end
        check("no_mismatch_without_load", mism_cnt, 0);

        // Overflow: five frames into a depth-4 FIFO with no consumer.
        out_ready = 1'b0;
        clear_mon();
        for (int f = 1; f <= 5; f++) send_frame(8'(f), 8);
        tick();
        check("ovf_fifo_count", {29'b0, fifo_count}, 32'd4);
        check("ovf_overflow",   {31'b0, overflow}, 32'd1);
        drain(4);
        repeat (3) tick();
        check("ovf_drain_n", got_q.size(), 4);
        for (int f = 0; f < 4; f++) begin
            w = (got_q.size() > f) ? got_q[f] : 8'hxx;
            check($sformatf("ovf_drain%0d", f), {24'b0, w}, 32'(f + 1));
        end
        check("ovf_sticky", {31'b0, overflow}, 32'd1);

        // Full FIFO with a pop coinciding with the push of 8'h77.
        out_ready = 1'b0;
        do_reset();
        send_frame(8'h11, 8);
        send_frame(8'h22, 8);
        send_frame(8'h33, 8);
        send_frame(8'h44, 8);
        send_bits(8'h77, 7);
        check("sim_full_before", {29'b0, fifo_count}, 32'd4);
        out_ready = 1'b1;
        data_mark = 1'b1;
        serial_in = 1'b1;
        tick();
        out_ready = 1'b0;
        data_mark = 1'b0;
        serial_in = 1'b0;
        check("sim_fifo_count", {29'b0, fifo_count}, 32'd4);
        check("sim_overflow",   {31'b0, overflow}, 32'd0);
        check("sim_head",       {24'b0, out_data}, 32'h22);
        tick();
        clear_mon();
        drain(4);
        repeat (2) tick();
        check("sim_drain_n", got_q.size(), 4);
        w = (got_q.size() > 3) ? got_q[3] : 8'hxx;
        check("sim_last_word", {24'b0, w}, 32'h77);

        // Reset mid-frame: no frame_err, nothing stored, next frame clean.
        out_ready = 1'b1;
        clear_mon();
        send_bits(8'hC3, 4);
        clr = 1'b0;
        #2;
        check("midrst_count", {29'b0, fifo_count}, 32'd0);
        data_mark = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        send_frame(8'h96, 8);
        repeat (3) tick();
        check("midrst_frame_err", ferr_cnt, 0);
        check("midrst_words", got_q.size(), 1);
        w = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        check("midrst_word", {24'b0, w}, 32'h96);

`ifdef ADC_RX_CHECK_EN
        clear_mon();
        b_par    = 8'h5A;
        load_reg = 1'b1;
        tick();
        load_reg = 1'b0;
        send_frame(8'h5A, 8);
        repeat (3) tick();
        check("chk_match_mismatch", mism_cnt, 0);

        clear_mon();
        load_reg = 1'b1;
        tick();
        load_reg = 1'b0;
        send_frame(8'h5B, 8);
        repeat (3) tick();
        check("chk_diff_mismatch", mism_cnt, 1);
        w = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        check("chk_diff_word", {24'b0, w}, 32'h5B);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
